// File: rtl/nco_pkg.sv
// ============================================================================
// nco_pkg : shared widths and sweep-FSM state encoding for the NCO sweeper
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package nco_pkg;

   localparam int NCO_DW = 8;
   localparam int NCO_CW = 16;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_DWELL = 3'd2;
   localparam logic [2:0] S_STEP  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/nco_dwell_cnt.sv
// ============================================================================
// nco_dwell_cnt : loadable down-counter, o_last flags a count of exactly 1
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module nco_dwell_cnt
   import nco_pkg::*;
#(
   parameter int CW = NCO_CW
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_load,
   input  logic [CW-1:0] i_val,
   input  logic          i_en,
   output logic          o_last
);

   logic [CW-1:0] count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count <= '0;
      end else if (i_load) begin
         count <= i_val;
      end else if (i_en && (count != '0)) begin
         count <= count - CW'(1);
      end
   end

   assign o_last = (count == CW'(1));

endmodule

`default_nettype wire

// File: rtl/nco_sweep_ctrl.sv
// ============================================================================
// nco_sweep_ctrl : steps NCO phase increment linearly from start to stop
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module nco_sweep_ctrl
   import nco_pkg::*;
#(
   parameter int DW = NCO_DW,
   parameter int CW = NCO_CW
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic          i_abort,
   input  logic          i_cont,
   input  logic [DW-1:0] i_f_start,
   input  logic [DW-1:0] i_f_stop,
   input  logic [DW-1:0] i_f_step,
   input  logic [CW-1:0] i_dwell,
   output logic [DW-1:0] o_dphase,
   output logic          o_ld,
   output logic          o_ce,
   output logic          o_busy,
   output logic          o_done
);

   logic [2:0]    state;
   logic [DW-1:0] cur;
   logic [DW-1:0] f_start_q;
   logic [DW-1:0] f_stop_q;
   logic [DW-1:0] f_step_q;
   logic [CW-1:0] dwell_q;
   logic          cont_q;

   logic [DW:0]   next_sum;
   logic          step_ok;
   logic          cnt_load;
   logic          cnt_en;
   logic          cnt_last;

   // Extra carry bit keeps the increment from wrapping past full scale.
   assign next_sum = {1'b0, cur} + {1'b0, f_step_q};
   assign step_ok  = (f_step_q != '0) && !next_sum[DW] && (next_sum[DW-1:0] <= f_stop_q);

   assign cnt_load = (state == S_LOAD) || (state == S_STEP);
   assign cnt_en   = (state == S_DWELL);

   nco_dwell_cnt #(
      .CW (CW)
   ) u_dwell_cnt (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (cnt_load),
      .i_val  (dwell_q),
      .i_en   (cnt_en),
      .o_last (cnt_last)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= S_IDLE;
         cur       <= '0;
         f_start_q <= '0;
         f_stop_q  <= '0;
         f_step_q  <= '0;
         dwell_q   <= '0;
         cont_q    <= 1'b0;
      end else if (i_abort) begin
         state <= S_IDLE;
         cur   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  state     <= S_LOAD;
                  cur       <= i_f_start;
                  f_start_q <= i_f_start;
                  f_stop_q  <= i_f_stop;
                  f_step_q  <= i_f_step;
                  dwell_q   <= (i_dwell == '0) ? CW'(1) : i_dwell;
                  cont_q    <= i_cont;
               end
            end
            S_LOAD: begin
               state <= S_DWELL;
            end
            S_DWELL: begin
               if (cnt_last) begin
                  state <= S_STEP;
               end
            end
            S_STEP: begin
               if (step_ok) begin
                  cur   <= next_sum[DW-1:0];
                  state <= S_DWELL;
               end else if (cont_q) begin
                  cur   <= f_start_q;
                  state <= S_LOAD;
               end else begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               cur   <= '0;
            end
            default: begin
               state <= S_IDLE;
               cur   <= '0;
            end
         endcase
      end
   end

   assign o_dphase = cur;
   assign o_ld     = (state == S_LOAD);
   assign o_ce     = (state == S_DWELL);
   assign o_busy   = (state != S_IDLE);
   assign o_done   = (state == S_DONE);

endmodule

`default_nettype wire

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Sequencer that drives an `nco` instance through a programmable linear frequency sweep. It steps the phase increment `i_dphase` from a start value to a stop value, holding each value for a programmable dwell. It pulses `i_ld` to reset NCO phase at sweep start and gates `i_ce`. It sits between the register/config logic and the `nco` datapath, and owns `i_dphase`, `i_ld` and `i_ce` of that instance.

## Interface
- `DW`, 8: phase-increment width; matches the NCO `i_dphase` width.
- `CW`, 16: dwell counter width.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  starts a sweep; sampled only in IDLE.
- `i_abort`  in  1  terminates a sweep; highest priority after reset.
- `i_cont`  in  1  0 = one-shot, 1 = restart from `i_f_start` after each pass; latched at start.
- `i_f_start`  in  DW  first increment; latched at start.
- `i_f_stop`  in  DW  last permitted increment, inclusive; latched.
- `i_f_step`  in  DW  increment added per step, unsigned; latched.
- `i_dwell`  in  CW  NCO-enabled cycles per frequency; 0 is treated as 1; latched.
- `o_dphase`  out  DW  to NCO `i_dphase`.
- `o_ld`  out  1  to NCO `i_ld`; single-cycle pulse.
- `o_ce`  out  1  to NCO `i_ce`.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse when a one-shot sweep completes.

## Operation
- States: IDLE, LOAD, DWELL, STEP, DONE.
- Reset, or abort in any state, sends the block to IDLE on the next edge, with all outputs 0.
- Reset value of every output is 0.
- Config registers are captured on the IDLE->LOAD transition. Input changes during a sweep have no effect.
- IDLE, `i_start`=1: go to LOAD.
- LOAD: `o_dphase`=f_start, `o_ld`=1, `o_ce`=0. Dwell counter is loaded with max(dwell,1). Go to DWELL.
- DWELL: `o_ce`=1 and the counter decrements. When the counter reaches 1, go to STEP.
- STEP: `o_ce`=0. Compute next = cur + step in DW+1 bits.
  - If step≠0, next ≤ stop and no carry: `o_dphase`<=next, reload the counter, go to DWELL. There is no `o_ld`, so NCO phase stays continuous.
  - Otherwise, end of pass: if cont, go to LOAD; else go to DONE.
- DONE: `o_done`=1 for exactly this cycle, `o_dphase` holds its last value, then go to IDLE.
- `i_start` is ignored while busy. `i_start` and `i_abort` together in IDLE: stay in IDLE.
- step=0, or f_start>f_stop: exactly one dwell at f_start, then end of pass.
- The comparison uses the carry bit, so the increment never wraps past 2^DW-1.

## Timing
- `i_start` sampled high in IDLE at edge t:
  - LOAD is visible in cycle t+1.
  - The first DWELL cycle is t+2.
- Each frequency takes 1 STEP cycle plus D DWELL cycles, where D = max(dwell,1). The new `o_dphase` is visible in the first DWELL cycle after STEP.
- One-shot sweep of K frequencies: `o_done` asserts in cycle t+2+K·(D+1). `o_busy` is high from t+1 through the `o_done` cycle inclusive.
- Continuous wrap: STEP -> LOAD -> DWELL, so the pass boundary costs 2 non-enabled cycles, with `o_ld` high in the LOAD cycle.
- Abort sampled at edge a: all outputs are 0 in cycle a+1; no `o_done`.

## Structure
- Shared package `nco_pkg`:
  - state encoding localparams: S_IDLE, S_LOAD, S_DWELL, S_STEP, S_DONE.
  - default widths `NCO_DW`=8 and `NCO_CW`=16.
- One sub-module `nco_dwell_cnt`, the loadable down-counter:
  - ports `i_clk`, `i_rst`, `i_load`, `i_val`, `i_en`, `o_last`.
  - `o_last` is high when the count is 1.
- FSM, config latches and the DW+1-bit adder/compare live in the top.

## Test plan
- Reset mid-DWELL, with start=10, stop=30, step=10, dwell=3 -> next cycle all outputs 0 and state IDLE. A new start then runs normally.
- One-shot sweep with start=10, stop=30, step=10, dwell=3, start at t:
  - `o_dphase` 10/20/30, each with 3 `o_ce` cycles.
  - `o_ld` only at t+1.
  - `o_done` at t+14.
  - `o_busy` high t+1..t+14.
- Overflow case, start=250, stop=255, step=10, dwell=0 -> one `o_ce` cycle at 250, `o_done` at t+4, no wrap to 4.
- Continuous mode, start=5, stop=7, step=2, dwell=2 -> sequence 5,7,5,7,... with `o_ld` on every return to 5. Abort -> outputs 0 next cycle, no `o_done`.
- `i_start` re-pulsed and inputs changed mid-sweep -> sweep unaffected. step=0 -> single dwell at f_start then `o_done`.
